// File: rtl/rom_access_arbiter.sv
// Two-port arbiter sharing one instruction ROM between fetch (IF) and data reads (DM).
// Define ROM_ARB_ROUND_ROBIN_EN to alternate on contention; default is fixed IF > DM.
module rom_access_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    input  logic                  if_ready,
    input  logic                  dm_req,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    input  logic                  dm_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;  // 0: IF, 1: DM
    logic                  if_gnt_q, if_gnt_d;
    logic                  dm_gnt_q, dm_gnt_d;
    logic                  if_valid_q, if_valid_d;
    logic                  dm_valid_q, dm_valid_d;
    logic                  rom_cs_q, rom_cs_d;
    logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic any_req;
    logic grant_dm;
    logic do_grant;
    logic owner_ready;
    logic prefer_dm;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;  // 0: IF served last, 1: DM served last

    assign prefer_dm = ~last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (do_grant) begin
            last_d = grant_dm;
        end
    end
`else
    assign prefer_dm = 1'b0;
`endif

    assign any_req     = if_req | dm_req;
    assign grant_dm    = dm_req & (~if_req | prefer_dm);
    assign owner_ready = owner_q ? dm_ready : if_ready;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        if_gnt_d      = 1'b0;
        dm_gnt_d      = 1'b0;
        if_valid_d    = if_valid_q;
        dm_valid_d    = dm_valid_q;
        rom_cs_d      = 1'b0;
        rom_address_d = rom_address_q;
        rsp_data_d    = rsp_data_q;
        do_grant      = 1'b0;

        case (state_q)
            StIdle: begin
                do_grant = any_req;
            end
            StAccess: begin
                rsp_data_d = rom_data;
                if (owner_q) begin
                    dm_valid_d = 1'b1;
                end else begin
                    if_valid_d = 1'b1;
                end
                state_d = StResp;
            end
            StResp: begin
                if (owner_ready) begin
                    if_valid_d = 1'b0;
                    dm_valid_d = 1'b0;
                    do_grant   = any_req;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Grant path is shared by IDLE and RESP so back-to-back reads lose no cycle.
        if (do_grant) begin
            owner_d       = grant_dm;
            rom_address_d = grant_dm ? dm_addr : if_addr;
            if_gnt_d      = ~grant_dm;
            dm_gnt_d      = grant_dm;
            rom_cs_d      = 1'b1;
            state_d       = StAccess;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            if_gnt_q      <= 1'b0;
            dm_gnt_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            dm_valid_q    <= 1'b0;
            rom_cs_q      <= 1'b0;
            rom_address_q <= '0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            if_gnt_q      <= if_gnt_d;
            dm_gnt_q      <= dm_gnt_d;
            if_valid_q    <= if_valid_d;
            dm_valid_q    <= dm_valid_d;
            rom_cs_q      <= rom_cs_d;
            rom_address_q <= rom_address_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign if_gnt      = if_gnt_q;
    assign dm_gnt      = dm_gnt_q;
    assign if_valid    = if_valid_q;
    assign dm_valid    = dm_valid_q;
    assign rom_cs      = rom_cs_q;
    assign rom_address = rom_address_q;
    assign rsp_data    = rsp_data_q;

endmodule
